// File: rtl/drive_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : drive_pkg                                              |
// | Description : Shared types and constants for the H-bridge drive      |
// |               sequencer: state encoding, bridge direction codes and  |
// |               switch-to-duty helpers.                                |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package drive_pkg;

    // Sequencer states; the encoding is exported on state_dbg.
    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_DEAD  = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // H-bridge input patterns, bit 3 drives bridge input 4.
    localparam logic [3:0] DIR_FWD   = 4'b1001;
    localparam logic [3:0] DIR_REV   = 4'b0110;
    localparam logic [3:0] DIR_RIGHT = 4'b0101;
    localparam logic [3:0] DIR_LEFT  = 4'b1010;
    localparam logic [3:0] DIR_COAST = 4'b0000;

    // Duty contributed by each of the four duty switches.
    localparam logic [9:0] DUTY_QUARTER = 10'd250;

    // Direction request from sw[3:1] (left > right > reverse > forward).
    function automatic logic [3:0] resolve_dir(input logic [2:0] req);
        logic [3:0] dir;
        if (req[2])      dir = DIR_LEFT;
        else if (req[1]) dir = DIR_RIGHT;
        else if (req[0]) dir = DIR_REV;
        else             dir = DIR_FWD;
        return dir;
    endfunction

    // Target duty: one quarter of full scale per switch that is on.
    function automatic logic [9:0] quarters_to_duty(input logic [3:0] q);
        logic [9:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            if (q[i]) d = d + DUTY_QUARTER;
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pwm_gen                                                |
// | Description : Free-running PWM counter (0..PWM_PERIOD-1) and duty    |
// |               compare. pulse is high while count < duty.             |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module pwm_gen #(
    parameter int PWM_PERIOD = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] duty,
    output logic       pulse
);

    localparam logic [9:0] c_cnt_last = 10'(PWM_PERIOD - 1);

    logic [9:0] r_cnt;

    // Period counter wraps to zero after the last count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 10'd1;
        end
    end

    // Duty 0 never matches, full-period duty always matches.
    assign pulse = (r_cnt < duty);

endmodule
`default_nettype wire

// File: rtl/drive_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : drive_sequencer                                        |
// | Description : H-bridge motor sequencer. Synchronizes switches and    |
// |               overcurrent, sequences OFF/DEAD/RUN/FAULT with coast   |
// |               dead time, ramps PWM duty toward the switch target.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module drive_sequencer
    import drive_pkg::*;
#(
    parameter int PWM_PERIOD   = 1000,
    parameter int DEAD_CYCLES  = 100000,
    parameter int RAMP_CYCLES  = 1000,
    parameter int RAMP_STEP    = 10,
    parameter int RETRY_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic [1:0] oc,
    output logic [1:0] en,
    output logic [3:0] hb_in,
    output logic       fault,
    output logic [1:0] state_dbg
);

    localparam int c_dead_w = (DEAD_CYCLES  > 1) ? $clog2(DEAD_CYCLES)  : 1;
    localparam int c_ramp_w = (RAMP_CYCLES  > 1) ? $clog2(RAMP_CYCLES)  : 1;
    localparam int c_hold_w = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;

    localparam logic [c_dead_w-1:0] c_dead_last = c_dead_w'(DEAD_CYCLES - 1);
    localparam logic [c_ramp_w-1:0] c_ramp_last = c_ramp_w'(RAMP_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(RETRY_CYCLES - 1);
    localparam logic [10:0]         c_step      = 11'(RAMP_STEP);

    // Synchronizers
    logic [7:0] r_sw_s1;
    logic [7:0] r_sw_s2;
    logic [1:0] r_oc_s1;
    logic [1:0] r_oc_s2;

    // Sequencer state and timers
    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_dir;
    logic [c_dead_w-1:0] r_dead_cnt;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic [c_ramp_w-1:0] r_ramp_cnt;
    logic [9:0]          r_duty_cur;
    logic                r_rearm;

    // Registered outputs
    logic [1:0] r_en;
    logic [3:0] r_hb_in;
    logic       r_fault;

    // Decoded requests
    logic       w_run_req;
    logic       w_oc_any;
    logic [3:0] w_dir_req;
    logic [9:0] w_duty_tgt;
    logic       w_dead_done;
    logic       w_hold_done;
    logic       w_ramp_tick;
    logic       w_pulse;

    // Ramp arithmetic
    logic [10:0] w_duty_ext;
    logic [10:0] w_tgt_ext;
    logic [10:0] w_duty_up;
    logic [10:0] w_duty_dn;
    logic [10:0] w_dist;
    logic [9:0]  w_duty_step;

    // Two-flop synchronizers for the switch bank and overcurrent pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
            r_oc_s1 <= '0;
            r_oc_s2 <= '0;
        end else begin
            r_sw_s1 <= sw;
            r_sw_s2 <= r_sw_s1;
            r_oc_s1 <= oc;
            r_oc_s2 <= r_oc_s1;
        end
    end

    assign w_run_req   = r_sw_s2[0];
    assign w_oc_any    = |r_oc_s2;
    assign w_dir_req   = resolve_dir(r_sw_s2[3:1]);
    assign w_duty_tgt  = quarters_to_duty(r_sw_s2[7:4]);
    assign w_dead_done = (r_dead_cnt == c_dead_last);
    assign w_hold_done = (r_hold_cnt == c_hold_last);
    assign w_ramp_tick = (r_ramp_cnt == c_ramp_last);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; overcurrent always wins, then the run switch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_OFF: begin
                // After a fault the run switch must be seen low before restarting.
                if (w_run_req && !r_rearm) w_state_nxt = S_DEAD;
            end
            S_DEAD: begin
                if (w_oc_any)                              w_state_nxt = S_FAULT;
                else if (!w_run_req)                       w_state_nxt = S_OFF;
                else if (w_dir_req == r_dir && w_dead_done) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_oc_any)                w_state_nxt = S_FAULT;
                else if (!w_run_req)         w_state_nxt = S_OFF;
                else if (w_dir_req != r_dir) w_state_nxt = S_DEAD;
            end
            S_FAULT: begin
                if (w_hold_done && !w_oc_any) w_state_nxt = S_OFF;
            end
            default: w_state_nxt = S_OFF;
        endcase
    end

    // Restart interlock: set on fault exit, cleared once run is released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rearm <= 1'b0;
        end else if (r_state == S_FAULT && w_state_nxt == S_OFF) begin
            r_rearm <= 1'b1;
        end else if (!w_run_req) begin
            r_rearm <= 1'b0;
        end
    end

    // Dead-time counter and direction latch; a new request restarts the coast.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dead_cnt <= '0;
            r_dir      <= DIR_FWD;
        end else if (w_state_nxt == S_DEAD) begin
            if (r_state != S_DEAD || w_dir_req != r_dir) begin
                r_dead_cnt <= '0;
                r_dir      <= w_dir_req;
            end else if (!w_dead_done) begin
                r_dead_cnt <= r_dead_cnt + 1'b1;
            end
        end else begin
            r_dead_cnt <= '0;
        end
    end

    // Fault hold counter saturates; oc re-assertion does not restart it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else if (w_state_nxt == S_FAULT) begin
            if (r_state != S_FAULT) begin
                r_hold_cnt <= '0;
            end else if (!w_hold_done) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end else begin
            r_hold_cnt <= '0;
        end
    end

    assign w_duty_ext = {1'b0, r_duty_cur};
    assign w_tgt_ext  = {1'b0, w_duty_tgt};
    assign w_duty_up  = w_duty_ext + c_step;
    assign w_duty_dn  = w_duty_ext - c_step;

    // One ramp step toward the target, landing exactly on it when close.
    always_comb begin
        w_duty_step = r_duty_cur;
        w_dist      = '0;
        if (w_tgt_ext > w_duty_ext) begin
            w_dist      = w_tgt_ext - w_duty_ext;
            w_duty_step = (w_dist > c_step) ? w_duty_up[9:0] : w_duty_tgt;
        end else if (w_tgt_ext < w_duty_ext) begin
            w_dist      = w_duty_ext - w_tgt_ext;
            w_duty_step = (w_dist > c_step) ? w_duty_dn[9:0] : w_duty_tgt;
        end
    end

    // Duty ramp runs only while staying in RUN; any other state parks at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ramp_cnt <= '0;
            r_duty_cur <= '0;
        end else if (r_state == S_RUN && w_state_nxt == S_RUN) begin
            if (w_ramp_tick) begin
                r_ramp_cnt <= '0;
                r_duty_cur <= w_duty_step;
            end else begin
                r_ramp_cnt <= r_ramp_cnt + 1'b1;
            end
        end else begin
            r_ramp_cnt <= '0;
            r_duty_cur <= '0;
        end
    end

    pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD)
    ) u_pwm_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (r_duty_cur),
        .pulse (w_pulse)
    );

    // Outputs follow the next state so the bridge coasts on the same edge
    // the state machine leaves RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en    <= 2'b00;
            r_hb_in <= DIR_COAST;
            r_fault <= 1'b0;
        end else begin
            if (w_state_nxt == S_RUN) begin
                r_en    <= {w_pulse, w_pulse};
                r_hb_in <= r_dir;
            end else begin
                r_en    <= 2'b00;
                r_hb_in <= DIR_COAST;
            end
            r_fault <= (w_state_nxt == S_FAULT);
        end
    end

    assign en        = r_en;
    assign hb_in     = r_hb_in;
    assign fault     = r_fault;
    assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_drive_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_drive_sequencer                                     |
// | Description : Directed self-checking bench for drive_sequencer with  |
// |               short dead/ramp/retry timings.                         |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_drive_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [1:0] oc = 2'b00;
    logic [1:0] en;
    logic [3:0] hb_in;
    logic       fault;
    logic [1:0] state_dbg;

    int n_pass  = 0;
    int n_total = 0;
    int viol    = 0;
    int enmis   = 0;
    logic [3:0] last_nz = 4'b0000;
    int zrun = 0;

    typedef struct {
        logic [7:0] sw;
        logic [1:0] st;
        logic [3:0] hb;
        int         duty;
        int         en_hi;
    } vec_t;

    vec_t vecs[7];

    drive_sequencer #(
        .PWM_PERIOD   (1000),
        .DEAD_CYCLES  (8),
        .RAMP_CYCLES  (4),
        .RAMP_STEP    (10),
        .RETRY_CYCLES (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .oc        (oc),
        .en        (en),
        .hb_in     (hb_in),
        .fault     (fault),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Watch for direct nonzero-to-nonzero bridge swaps and A/B enable skew.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_nz <= 4'b0000;
            zrun    <= 0;
        end else if (hb_in == 4'b0000) begin
            zrun <= zrun + 1;
        end else begin
            if (last_nz != 4'b0000 && hb_in != last_nz && zrun < 8) viol <= viol + 1;
            last_nz <= hb_in;
            zrun    <= 0;
        end
        if (en[0] != en[1]) enmis <= enmis + 1;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sw    = 8'h00;
        oc    = 2'b00;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
        int k;
        k = 0;
        while (state_dbg != s && k < budget) begin
            cyc(1);
            k++;
        end
        check(nm, int'(state_dbg), int'(s));
    endtask

    initial begin
        int k, d, z, f, hbbad, hi, mn, bad;

        vecs[0] = '{sw: 8'h01, st: 2'd2, hb: 4'b1001, duty: 0,    en_hi: 0};
        vecs[1] = '{sw: 8'h13, st: 2'd2, hb: 4'b0110, duty: 250,  en_hi: 250};
        vecs[2] = '{sw: 8'h35, st: 2'd2, hb: 4'b0101, duty: 500,  en_hi: 500};
        vecs[3] = '{sw: 8'h79, st: 2'd2, hb: 4'b1010, duty: 750,  en_hi: 750};
        vecs[4] = '{sw: 8'hFF, st: 2'd2, hb: 4'b1010, duty: 1000, en_hi: 1000};
        vecs[5] = '{sw: 8'h87, st: 2'd2, hb: 4'b0101, duty: 250,  en_hi: 250};
        vecs[6] = '{sw: 8'h0E, st: 2'd0, hb: 4'b0000, duty: 0,    en_hi: 0};

        // Reset values with all inputs driven high during reset.
        rst_n = 1'b0;
        sw    = 8'hFF;
        oc    = 2'b11;
        cyc(3);
        check("rst_state", int'(state_dbg), 0);
        check("rst_en", int'(en), 0);
        check("rst_hb", int'(hb_in), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_duty", int'(dut.r_duty_cur), 0);

        // Table: direction priority, target duty and PWM high time.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            sw = vecs[i].sw;
            if (vecs[i].st == 2'd2) begin
                wait_state(2'd2, 40, "vec_reach_run");
            end else begin
                cyc(20);
                check("vec_state_off", int'(state_dbg), 0);
            end
            cyc((vecs[i].duty / 10) * 4 + 8);
            check("vec_hb", int'(hb_in), int'(vecs[i].hb));
            check("vec_duty", int'(dut.r_duty_cur), vecs[i].duty);
            hi = 0;
            repeat (1000) begin
                cyc(1);
                if (en[0]) hi++;
            end
            check("vec_en_high", hi, vecs[i].en_hi);
        end

        // Start: dead time, then forward with ramp from zero.
        do_reset();
        sw = 8'h11;
        wait_state(2'd1, 5, "start_dead");
        d = 0;
        hbbad = 0;
        while (state_dbg == 2'd1 && d < 30) begin
            if (hb_in != 4'b0000) hbbad++;
            d++;
            cyc(1);
        end
        check("start_dead_len", d, 8);
        check("start_dead_hb0", hbbad, 0);
        check("start_run_state", int'(state_dbg), 2);
        check("start_run_hb", int'(hb_in), 9);
        check("start_duty0", int'(dut.r_duty_cur), 0);
        for (int s = 1; s <= 3; s++) begin
            cyc(4);
            check("start_ramp", int'(dut.r_duty_cur), s * 10);
        end
        cyc(100);
        check("start_duty_hold", int'(dut.r_duty_cur), 250);

        // Reverse: coast within 3 cycles, 8 cycles of 0000, restart at duty 0.
        sw = 8'h13;
        k = 0;
        while (!(en == 2'b00 && hb_in == 4'b0000) && k < 6) begin
            cyc(1);
            k++;
        end
        check("rev_coast_fast", int'(k <= 3), 1);
        z = 0;
        while (hb_in == 4'b0000 && z < 30) begin
            z++;
            cyc(1);
        end
        check("rev_dead_len", z, 8);
        check("rev_hb", int'(hb_in), 6);
        check("rev_duty0", int'(dut.r_duty_cur), 0);

        // Overcurrent pulse: fault within 4 edges, 20-cycle hold, latched off.
        cyc(20);
        oc = 2'b01;
        cyc(1);
        oc = 2'b00;
        k = 0;
        while (!fault && k < 8) begin
            cyc(1);
            k++;
        end
        check("oc_latency", int'((k + 1) <= 4), 1);
        check("oc_en_off", int'(en), 0);
        check("oc_hb_off", int'(hb_in), 0);
        f = 0;
        while (fault && f < 40) begin
            f++;
            cyc(1);
        end
        check("oc_hold_len", f, 20);
        check("oc_exit_off", int'(state_dbg), 0);
        cyc(20);
        check("oc_stay_off", int'(state_dbg), 0);
        sw = 8'h10;
        cyc(3);
        sw = 8'h11;
        wait_state(2'd1, 5, "oc_rearm_dead");

        // Sustained oc holds FAULT; exit 3 edges after the pin clears.
        wait_state(2'd2, 30, "hold_reach_run");
        oc = 2'b10;
        cyc(50);
        check("hold_in_fault", int'(state_dbg), 3);
        check("hold_fault_flag", int'(fault), 1);
        oc = 2'b00;
        k = 0;
        while (state_dbg != 2'd0 && k < 10) begin
            cyc(1);
            k++;
        end
        check("hold_exit_delay", k, 3);

        // Left wins over right; ramp down 1000 -> 250 without undershoot.
        do_reset();
        sw = 8'hFD;
        wait_state(2'd2, 40, "prio_reach_run");
        cyc(410);
        check("prio_hb_left", int'(hb_in), 10);
        check("prio_duty_full", int'(dut.r_duty_cur), 1000);
        sw = 8'h1D;
        mn = 1000;
        bad = 0;
        repeat (320) begin
            cyc(1);
            if (int'(dut.r_duty_cur) < mn) mn = int'(dut.r_duty_cur);
            if ((int'(dut.r_duty_cur) % 10) != 0) bad++;
        end
        check("down_final", int'(dut.r_duty_cur), 250);
        check("down_min", mn, 250);
        check("down_step_grid", bad, 0);
        check("down_hb_kept", int'(hb_in), 10);

        // Reset in DEAD.
        sw = 8'h13;
        wait_state(2'd1, 6, "mid_dead_reach");
        cyc(3);
        rst_n = 1'b0;
        cyc(1);
        check("rdead_state", int'(state_dbg), 0);
        check("rdead_hb", int'(hb_in), 0);
        check("rdead_en", int'(en), 0);
        check("rdead_duty", int'(dut.r_duty_cur), 0);
        rst_n = 1'b1;

        // Reset in FAULT.
        do_reset();
        sw = 8'h11;
        wait_state(2'd2, 40, "mid_fault_run");
        oc = 2'b01;
        wait_state(2'd3, 8, "mid_fault_reach");
        rst_n = 1'b0;
        cyc(1);
        check("rfault_state", int'(state_dbg), 0);
        check("rfault_fault", int'(fault), 0);
        check("rfault_en", int'(en), 0);
        check("rfault_hb", int'(hb_in), 0);
        oc = 2'b00;
        rst_n = 1'b1;
        cyc(2);

        check("hb_no_direct_swap", viol, 0);
        check("en_a_b_equal", enmis, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
